// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
// ----------------
// Fetch/decode/issue sequencer that drives a 20-bit combinational ALU from
// the initiator side. Instructions are fetched over a req/ack port. Each
// instruction is decoded against an 8x20 register file. ALU opcode and
// operands are presented for one EXEC cycle, and the ALU outputs are sampled
// at the end of that cycle. Results or flags are written back in WB.
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   start                leave IDLE/HALTED and begin fetching
//   imem_req/addr        fetch request and address (PC)
//   imem_ack/rdata       fetch accept and instruction word (same cycle)
//   alu_op/a/b/cin       ALU opcode, operands and carry-in (zero op outside EXEC)
//   alu_result/cout/z/n  ALU outputs, sampled at the closing edge of EXEC
//   flag_z/n/c           architectural flags
//   busy, halted, err    status (err is sticky until restart)
//   dbg_sel/dbg_data     combinational register file peek

module alu_issue_ctrl #(
  parameter logic [19:0] PC_RESET = 20'h00000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        imem_req,
  output logic [19:0] imem_addr,
  input  logic        imem_ack,
  input  logic [19:0] imem_rdata,
  output logic [19:0] alu_op,
  output logic [19:0] alu_a,
  output logic [19:0] alu_b,
  output logic        alu_cin,
  input  logic [19:0] alu_result,
  input  logic        alu_cout,
  input  logic        alu_z,
  input  logic        alu_n,
  output logic        flag_z,
  output logic        flag_n,
  output logic        flag_c,
  output logic        busy,
  output logic        halted,
  output logic        err,
  input  logic [2:0]  dbg_sel,
  output logic [19:0] dbg_data
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_WB, ST_WB1, ST_WB2, ST_HALTED
  } state_t;

  localparam logic [4:0] OP_SWAP = 5'd8;
  localparam logic [4:0] OP_ADDC = 5'd12;
  localparam logic [4:0] OP_SUBC = 5'd14;
  localparam logic [4:0] OP_EQ   = 5'd15;
  localparam logic [4:0] OP_LET  = 5'd19;
  localparam logic [4:0] OP_LDI  = 5'd20;
  localparam logic [4:0] OP_HALT = 5'd31;

  // Op index to ALU opcode code; indices outside 0..19 never reach EXEC.
  function automatic logic [19:0] op_code(input logic [4:0] idx);
    logic [19:0] code;
    case (idx)
      5'd0:    code = 20'h000A1;
      5'd1:    code = 20'h000C9;
      5'd2:    code = 20'h000B5;
      5'd3:    code = 20'h000DD;
      5'd4:    code = 20'h000F1;
      5'd5:    code = 20'h00105;
      5'd6:    code = 20'h00119;
      5'd7:    code = 20'h0012D;
      5'd8:    code = 20'h00011;
      5'd9:    code = 20'h00141;
      5'd10:   code = 20'h00155;
      5'd11:   code = 20'h00169;
      5'd12:   code = 20'h0017D;
      5'd13:   code = 20'h00191;
      5'd14:   code = 20'h001A5;
      5'd15:   code = 20'h001B9;
      5'd16:   code = 20'h001CD;
      5'd17:   code = 20'h001E1;
      5'd18:   code = 20'h001F5;
      5'd19:   code = 20'h00209;
      default: code = 20'h00000;
    endcase
    return code;
  endfunction

  state_t      state_reg;
  logic [19:0] pc_reg;
  logic [19:0] instr_reg;
  logic        imem_req_reg;
  logic [19:0] alu_op_reg;
  logic [19:0] alu_a_reg;
  logic [19:0] alu_b_reg;
  logic        alu_cin_reg;
  logic [19:0] res_reg;
  logic        res_cout_reg;
  logic        res_z_reg;
  logic        res_n_reg;
  logic        flag_z_reg;
  logic        flag_n_reg;
  logic        flag_c_reg;
  logic        busy_reg;
  logic        halted_reg;
  logic        err_reg;

  logic [19:0] regs [0:7];

  logic [4:0]  op_idx;
  logic [2:0]  rd;
  logic [2:0]  ra;
  logic [2:0]  rb;
  logic [11:0] imm;

  assign op_idx = instr_reg[19:15];
  assign rd     = instr_reg[14:12];
  assign ra     = instr_reg[11:9];
  assign rb     = instr_reg[8:6];
  assign imm    = instr_reg[11:0];

  // Register file write port, active only in the writeback states.
  // SWAP reuses the operands latched in DECODE (alu_a/alu_b hold regs[ra]
  // and regs[rb]), so the ALU result never feeds a swap.
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [19:0] wb_data;

  always_comb begin
    wb_en   = 1'b0;
    wb_addr = rd;
    wb_data = res_reg;
    case (state_reg)
      ST_WB: begin
        if (op_idx == OP_LDI) begin
          wb_en   = 1'b1;
          wb_data = {8'h00, imm};
        end else if ((op_idx < OP_SWAP) || ((op_idx > OP_SWAP) && (op_idx <= OP_SUBC))) begin
          wb_en = 1'b1;
        end
      end
      ST_WB1: begin
        wb_en   = 1'b1;
        wb_addr = ra;
        wb_data = alu_b_reg;
      end
      ST_WB2: begin
        wb_en   = 1'b1;
        wb_addr = rb;
        wb_data = alu_a_reg;
      end
      default: ;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_regfile
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          regs[gi] <= 20'h00000;
        end else if (wb_en && (wb_addr == 3'(gi))) begin
          regs[gi] <= wb_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      pc_reg       <= PC_RESET;
      instr_reg    <= 20'h00000;
      imem_req_reg <= 1'b0;
      alu_op_reg   <= 20'h00000;
      alu_a_reg    <= 20'h00000;
      alu_b_reg    <= 20'h00000;
      alu_cin_reg  <= 1'b0;
      res_reg      <= 20'h00000;
      res_cout_reg <= 1'b0;
      res_z_reg    <= 1'b0;
      res_n_reg    <= 1'b0;
      flag_z_reg   <= 1'b0;
      flag_n_reg   <= 1'b0;
      flag_c_reg   <= 1'b0;
      busy_reg     <= 1'b0;
      halted_reg   <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg <= ST_FETCH;
            busy_reg  <= 1'b1;
          end
        end

        // Request goes up one cycle after entering FETCH and stays up with
        // a stable address until acknowledged.
        ST_FETCH: begin
          if (!imem_req_reg) begin
            imem_req_reg <= 1'b1;
          end else if (imem_ack) begin
            instr_reg    <= imem_rdata;
            pc_reg       <= pc_reg + 20'd1;
            imem_req_reg <= 1'b0;
            state_reg    <= ST_DECODE;
          end
        end

        ST_DECODE: begin
          alu_a_reg <= regs[ra];
          alu_b_reg <= regs[rb];
          if (op_idx == OP_LDI) begin
            state_reg <= ST_WB;
          end else if (op_idx == OP_HALT) begin
            state_reg  <= ST_HALTED;
            busy_reg   <= 1'b0;
            halted_reg <= 1'b1;
          end else if (op_idx > OP_LDI) begin
            state_reg  <= ST_HALTED;
            busy_reg   <= 1'b0;
            halted_reg <= 1'b1;
            err_reg    <= 1'b1;
          end else begin
            state_reg   <= ST_EXEC;
            alu_op_reg  <= op_code(op_idx);
            alu_cin_reg <= flag_c_reg;
          end
        end

        ST_EXEC: begin
          res_reg      <= alu_result;
          res_cout_reg <= alu_cout;
          res_z_reg    <= alu_z;
          res_n_reg    <= alu_n;
          alu_op_reg   <= 20'h00000;
          state_reg    <= (op_idx == OP_SWAP) ? ST_WB1 : ST_WB;
        end

        ST_WB: begin
          if ((op_idx == OP_ADDC) || (op_idx == OP_SUBC)) begin
            flag_c_reg <= res_cout_reg;
          end
          if ((op_idx >= OP_EQ) && (op_idx <= OP_LET)) begin
            flag_z_reg <= res_z_reg;
            flag_n_reg <= res_n_reg;
          end
          state_reg <= ST_FETCH;
        end

        ST_WB1: state_reg <= ST_WB2;

        ST_WB2: state_reg <= ST_FETCH;

        ST_HALTED: begin
          if (start) begin
            err_reg    <= 1'b0;
            halted_reg <= 1'b0;
            busy_reg   <= 1'b1;
            pc_reg     <= PC_RESET;
            state_reg  <= ST_FETCH;
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign imem_req  = imem_req_reg;
  assign imem_addr = pc_reg;
  assign alu_op    = alu_op_reg;
  assign alu_a     = alu_a_reg;
  assign alu_b     = alu_b_reg;
  assign alu_cin   = alu_cin_reg;
  assign flag_z    = flag_z_reg;
  assign flag_n    = flag_n_reg;
  assign flag_c    = flag_c_reg;
  assign busy      = busy_reg;
  assign halted    = halted_reg;
  assign err       = err_reg;
  assign dbg_data  = regs[dbg_sel];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: the bench plays instruction memory and
// a stub ALU, keeps a register/flag model and a queue of expected EXEC issues.

module tb_alu_issue_ctrl;

  localparam logic [19:0] PC_RST = 20'hFFFFE;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        imem_req;
  logic [19:0] imem_addr;
  logic        imem_ack;
  logic [19:0] imem_rdata;
  logic [19:0] alu_op;
  logic [19:0] alu_a;
  logic [19:0] alu_b;
  logic        alu_cin;
  logic [19:0] alu_result;
  logic        alu_cout;
  logic        alu_z;
  logic        alu_n;
  logic        flag_z;
  logic        flag_n;
  logic        flag_c;
  logic        busy;
  logic        halted;
  logic        err;
  logic [2:0]  dbg_sel;
  logic [19:0] dbg_data;

  alu_issue_ctrl #(.PC_RESET(PC_RST)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_result(alu_result), .alu_cout(alu_cout), .alu_z(alu_z), .alu_n(alu_n),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c),
    .busy(busy), .halted(halted), .err(err),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int since_ack = 0;

  // Cycles since the last accepted fetch.
  always @(posedge clk) begin
    if (imem_req && imem_ack) since_ack <= 0;
    else since_ack <= since_ack + 1;
  end

  typedef struct packed {
    logic [19:0] op;
    logic [19:0] a;
    logic [19:0] b;
    logic        cin;
  } exp_t;

  exp_t        sb[$];
  logic [19:0] exp_pc;
  logic [19:0] mregs [8];
  logic        mz, mn, mc;

  task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%05h expected=%05h", tag, obs, expv);
    end
  endtask

  function automatic logic [19:0] mk(input logic [4:0] op, input logic [2:0] rd,
                                     input logic [2:0] ra, input logic [2:0] rb);
    return {op, rd, ra, rb, 6'h00};
  endfunction

  function automatic logic [19:0] mk_ldi(input logic [2:0] rd, input logic [11:0] imm);
    return {5'd20, rd, imm};
  endfunction

  task automatic issue(input logic [19:0] code, input logic [19:0] a, input logic [19:0] b);
    exp_t e;
    e.op = code; e.a = a; e.b = b; e.cin = mc;
    sb.push_back(e);
  endtask

  // Serve one fetch: wait for the request, check address/latency, optionally
  // withhold ack for 'hold' cycles, then accept 'instr'.
  task automatic fetch(input logic [19:0] instr, input int hold, input int exp_lat);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!imem_req && n < 30);
    if (!imem_req) begin
      chk("req_timeout", {19'h0, imem_req}, 20'd1);
      return;
    end
    if (exp_lat >= 0) chk("ack_to_req", 20'(since_ack), 20'(exp_lat));
    chk("imem_addr", imem_addr, exp_pc);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("req_held", {19'h0, imem_req}, 20'd1);
      chk("addr_stable", imem_addr, exp_pc);
    end
    imem_rdata = instr;
    imem_ack   = 1'b1;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 20'h00000;
    chk("req_drop", {19'h0, imem_req}, 20'd0);
    exp_pc = exp_pc + 20'd1;
  endtask

  // Wait for EXEC, compare against the scoreboard head, drive the stub ALU.
  task automatic exec_step(input logic [19:0] res, input logic cout, input logic z, input logic n);
    exp_t e;
    int   k;
    k = 0;
    do begin @(negedge clk); k++; end while (alu_op === 20'h00000 && k < 10);
    checks++;
    assert (sb.size() > 0) else begin
      failures++;
      $error("FAIL sb_empty observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    chk("alu_op", alu_op, e.op);
    chk("alu_a", alu_a, e.a);
    chk("alu_b", alu_b, e.b);
    chk("alu_cin", {19'h0, alu_cin}, {19'h0, e.cin});
    alu_result = res;
    alu_cout   = cout;
    alu_z      = z;
    alu_n      = n;
    @(negedge clk);
    chk("alu_op_idle", alu_op, 20'h00000);
  endtask

  // Compare register file and flags with the model (stays within half a cycle).
  task automatic check_model();
    for (int i = 0; i < 8; i++) begin
      dbg_sel = 3'(i);
      #1;
      chk($sformatf("dbg_r%0d", i), dbg_data, mregs[i]);
    end
    chk("flag_z", {19'h0, flag_z}, {19'h0, mz});
    chk("flag_n", {19'h0, flag_n}, {19'h0, mn});
    chk("flag_c", {19'h0, flag_c}, {19'h0, mc});
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; imem_ack = 1'b0; imem_rdata = 20'h00000;
    alu_result = 20'h00000; alu_cout = 1'b0; alu_z = 1'b0; alu_n = 1'b0;
    dbg_sel = 3'd0;
    exp_pc = PC_RST; mz = 1'b0; mn = 1'b0; mc = 1'b0;
    for (int i = 0; i < 8; i++) mregs[i] = 20'h00000;

    repeat (3) @(negedge clk);
    chk("rst_busy", {19'h0, busy}, 20'd0);
    chk("rst_halted", {19'h0, halted}, 20'd0);
    chk("rst_err", {19'h0, err}, 20'd0);
    chk("rst_req", {19'h0, imem_req}, 20'd0);
    chk("rst_alu_op", alu_op, 20'h00000);
    chk("rst_addr", imem_addr, PC_RST);

    // Reset in the middle of a fetch.
    rst_n = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    chk("req_up", {19'h0, imem_req}, 20'd1);
    chk("busy_fetch", {19'h0, busy}, 20'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_req", {19'h0, imem_req}, 20'd0);
    chk("midrst_busy", {19'h0, busy}, 20'd0);
    chk("midrst_addr", imem_addr, PC_RST);
    check_model();

    start = 1'b1;
    @(negedge clk); start = 1'b0;

    // LDI / ADD with PC wrap FFFFE -> FFFFF -> 00000.
    fetch(mk_ldi(3'd1, 12'h005), 0, -1); mregs[1] = 20'h00005;
    fetch(mk_ldi(3'd2, 12'h003), 0, 3);  mregs[2] = 20'h00003;
    issue(20'h00169, 20'h00005, 20'h00003);
    fetch(mk(5'd11, 3'd3, 3'd1, 3'd2), 0, 3);
    exec_step(20'h00008, 1'b0, 1'b0, 1'b0); mregs[3] = 20'h00008;

    // ADDC sets C; Z/N ignored; the next ADDC sees cin=1.
    issue(20'h0017D, 20'h00005, 20'h00003);
    fetch(mk(5'd12, 3'd4, 3'd1, 3'd2), 0, 4);
    check_model();
    exec_step(20'h00009, 1'b1, 1'b1, 1'b1); mregs[4] = 20'h00009; mc = 1'b1;
    issue(20'h0017D, 20'h00005, 20'h00003);
    fetch(mk(5'd12, 3'd5, 3'd1, 3'd2), 0, 4);
    check_model();
    exec_step(20'h00099, 1'b0, 1'b0, 1'b0); mregs[5] = 20'h00099; mc = 1'b0;

    // SWAP ignores the ALU result.
    fetch(mk_ldi(3'd1, 12'h00A), 0, 4); mregs[1] = 20'h0000A;
    fetch(mk_ldi(3'd2, 12'h0F0), 0, 3); mregs[2] = 20'h000F0;
    issue(20'h00011, 20'h0000A, 20'h000F0);
    fetch(mk(5'd8, 3'd0, 3'd1, 3'd2), 0, 3);
    exec_step(20'h12345, 1'b1, 1'b1, 1'b1);
    mregs[1] = 20'h000F0; mregs[2] = 20'h0000A;

    // Compares load Z/N only.
    issue(20'h001B9, 20'h000F0, 20'h0000A);
    fetch(mk(5'd15, 3'd7, 3'd1, 3'd2), 0, 5);
    check_model();
    exec_step(20'hABCDE, 1'b1, 1'b1, 1'b0); mz = 1'b1; mn = 1'b0;
    issue(20'h001E1, 20'h00008, 20'h00009);
    fetch(mk(5'd17, 3'd6, 3'd3, 3'd4), 0, 4);
    check_model();
    exec_step(20'h11111, 1'b1, 1'b0, 1'b1); mz = 1'b0; mn = 1'b1;

    // SWAP with ra==rb, then XOR.
    issue(20'h00011, 20'h00008, 20'h00008);
    fetch(mk(5'd8, 3'd0, 3'd3, 3'd3), 0, 4);
    exec_step(20'h00000, 1'b0, 1'b0, 1'b0);
    issue(20'h000DD, 20'h00009, 20'h00099);
    fetch(mk(5'd3, 3'd6, 3'd4, 3'd5), 0, 5);
    check_model();
    exec_step(20'h00090, 1'b0, 1'b0, 1'b0); mregs[6] = 20'h00090;

    // Illegal opcode with the ack withheld for 3 cycles.
    fetch(mk(5'd25, 3'd1, 3'd2, 3'd3), 3, 4);
    @(negedge clk);
    chk("ill_err", {19'h0, err}, 20'd1);
    chk("ill_halted", {19'h0, halted}, 20'd1);
    chk("ill_busy", {19'h0, busy}, 20'd0);
    repeat (2) @(negedge clk);
    chk("halt_no_req", {19'h0, imem_req}, 20'd0);
    check_model();

    // Restart from HALTED.
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("restart_err", {19'h0, err}, 20'd0);
    chk("restart_halted", {19'h0, halted}, 20'd0);
    chk("restart_busy", {19'h0, busy}, 20'd1);
    chk("restart_addr", imem_addr, PC_RST);
    exp_pc = PC_RST;

    // start held high while busy has no effect; HALT stops without err.
    fetch(mk_ldi(3'd0, 12'hFFF), 0, -1); mregs[0] = 20'h00FFF;
    start = 1'b1;
    fetch(mk(5'd31, 3'd0, 3'd0, 3'd0), 0, 3);
    start = 1'b0;
    @(negedge clk);
    chk("halt_halted", {19'h0, halted}, 20'd1);
    chk("halt_err", {19'h0, err}, 20'd0);
    chk("halt_busy", {19'h0, busy}, 20'd0);
    check_model();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
